conv_feature_writer: RTL

//  Output stage of the conv layer, fed by the kernel array's feature bus. Captures one

---
 rtl/conv_layer_pkg.sv | 27 ++
 rtl/conv_row_pingpong.sv | 52 +++++
 rtl/conv_feature_writer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/conv_layer_pkg.sv
// Shared types and helpers for the conv layer output path: fp32 word/row types,
// ReLU on a raw fp32 bit pattern, and element selection within a packed row.
package conv_layer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ARRAY_SIZE = 6;
  localparam int SIGN_BIT   = DATA_WIDTH - 1;

  typedef logic [DATA_WIDTH-1:0]            word_t;
  typedef logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wr_state_e;

  // Any word with the sign bit set (including -0.0 and negative NaN) becomes +0.0.
  function automatic word_t relu(input word_t w);
    return w[SIGN_BIT] ? '0 : w;
  endfunction

  // Element 0 occupies the most significant slice of the row.
  function automatic word_t word_sel(input row_t r, input int i);
    return r[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/conv_row_pingpong.sv
// Two-entry row buffer: rows are written at the write pointer and read combinationally
// at the read pointer; count tracks occupancy for the producer/consumer handshake.
module conv_row_pingpong #(
  parameter int ROW_W = 192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [ROW_W-1:0] wr_row,
  output logic [ROW_W-1:0] rd_row,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [ROW_W-1:0] bank [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the row storage has no reset; occupancy is tracked by count, so stale
  // contents are never observable and the wide registers stay off the reset tree.
  always_ff @(posedge clk) begin
    if (push) bank[wr_ptr] <= wr_row;
  end

  assign rd_row = bank[rd_ptr];
  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);

endmodule

// File: rtl/conv_feature_writer.sv
// Output stage of the conv layer: captures kernel-array rows (optional ReLU) into a
// ping-pong buffer and serialises them word by word onto a valid/ready write port.
module conv_feature_writer #(
  parameter int DATA_WIDTH = conv_layer_pkg::DATA_WIDTH,
  parameter int ARRAY_SIZE = conv_layer_pkg::ARRAY_SIZE,
  parameter int OUT_ROWS   = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature,
  input  logic                             feature_valid,
  input  logic                             relu_en,
  input  logic                             flush,
  output logic                             feature_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             row_done,
  output logic                             frame_done,
  output logic                             overflow
);

  import conv_layer_pkg::*;

  localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  wr_state_e        state_q;
  wr_state_e        state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             row_done_q;
  logic             frame_done_q;
  logic             overflow_q;

  row_t       relu_row;
  row_t       rd_row;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       hs;
  logic       last_col;
  logic       last_row;

  // NOTE: combinational blocks assign every output a default first so no path
  // through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    relu_row = feature;
    if (relu_en) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        relu_row[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH] = relu(word_sel(feature, i));
      end
    end
  end

  // A row is only accepted when a bank is free; flush discards a same-cycle strobe.
  assign push     = feature_valid & ~full & ~flush;
  assign hs       = out_valid & out_ready;
  assign last_col = (col_q == COL_W'(ARRAY_SIZE - 1));
  assign last_row = (row_q == ROW_W'(OUT_ROWS - 1));
  assign pop      = hs & last_col & ~flush;

  conv_row_pingpong #(
    .ROW_W (ARRAY_SIZE*DATA_WIDTH)
  ) u_pingpong (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .push   (push),
    .pop    (pop),
    .wr_row (relu_row),
    .rd_row (rd_row),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Leaving DRAIN only when the bank just freed was the last one and nothing refills it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (push || !empty) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && (count == 2'd1) && !push) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (flush) begin
      col_q        <= '0;
      row_q        <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      row_done_q   <= pop;
      frame_done_q <= pop & last_row;
      if (feature_valid && full) overflow_q <= 1'b1;
      if (hs) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  assign out_valid     = (state_q == ST_DRAIN);
  assign feature_ready = ~full;
  assign out_data      = out_valid ? word_sel(rd_row, int'(col_q)) : '0;
  assign out_addr      = out_valid ? ADDR_WIDTH'(BASE_ADDR)
                                     + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(ARRAY_SIZE)
                                     + ADDR_WIDTH'(col_q)
                                   : '0;
  assign row_done      = row_done_q;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;

endmodule
